// File: rtl/shift_iter.sv
// Iterative barrel-less shifter: SLL/SRL/SRA/ROR performed STEP bits per cycle
// behind a valid/ready handshake on both request and result sides.
module shift_iter #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned SHAMT_W = 5,
  parameter int unsigned STEP    = 4
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_in_valid,
  output logic               o_in_ready,
  input  logic [WIDTH-1:0]   i_data_in,
  input  logic [SHAMT_W-1:0] i_shamt,
  input  logic [1:0]         i_mode,
  output logic               o_out_valid,
  input  logic               i_out_ready,
  output logic [WIDTH-1:0]   o_data_out
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam logic [SHAMT_W-1:0] LP_STEP  = SHAMT_W'(STEP);
  localparam logic [SHAMT_W:0]   LP_WIDTH = (SHAMT_W + 1)'(WIDTH);

  logic [1:0]         r_state;
  logic [WIDTH-1:0]   r_work;
  logic [SHAMT_W-1:0] r_rem;
  logic [1:0]         r_mode;

  logic [SHAMT_W-1:0] w_k;
  logic [SHAMT_W:0]   w_lsh;
  logic [WIDTH-1:0]   w_shifted;

  // k is never zero in SHIFT, so the ROR left-shift amount stays below WIDTH.
  always_comb begin
    w_k       = (r_rem < LP_STEP) ? r_rem : LP_STEP;
    w_lsh     = LP_WIDTH - {1'b0, w_k};
    w_shifted = r_work;
    unique case (r_mode)
      2'b00: w_shifted = r_work << w_k;
      2'b01: w_shifted = r_work >> w_k;
      2'b10: w_shifted = $signed(r_work) >>> w_k;
      2'b11: w_shifted = (r_work >> w_k) | (r_work << w_lsh);
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state <= S_IDLE;
      r_work  <= '0;
      r_rem   <= '0;
      r_mode  <= 2'b00;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_in_valid) begin
            r_work  <= i_data_in;
            r_rem   <= i_shamt;
            r_mode  <= i_mode;
            r_state <= (i_shamt == '0) ? S_DONE : S_SHIFT;
          end
        end
        S_SHIFT: begin
          r_work <= w_shifted;
          r_rem  <= r_rem - w_k;
          if (r_rem == w_k) r_state <= S_DONE;
        end
        S_DONE: begin
          if (i_out_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_in_ready  = (r_state == S_IDLE);
  assign o_out_valid = (r_state == S_DONE);
  assign o_data_out  = r_work;

endmodule

// File: tb/tb_shift_iter.sv
// Directed self-checking bench for shift_iter (WIDTH=32, STEP=4).
module tb_shift_iter;

  logic        i_clock = 1'b0;
  logic        i_reset;
  logic        i_in_valid;
  logic        o_in_ready;
  logic [31:0] i_data_in;
  logic [4:0]  i_shamt;
  logic [1:0]  i_mode;
  logic        o_out_valid;
  logic        i_out_ready;
  logic [31:0] o_data_out;

  int n_checks = 0;
  int n_pass   = 0;

  localparam logic [1:0] SLL = 2'b00, SRL = 2'b01, SRA = 2'b10, ROR = 2'b11;

  shift_iter #(
    .WIDTH  (32),
    .SHAMT_W(5),
    .STEP   (4)
  ) dut (
    .i_clock    (i_clock),
    .i_reset    (i_reset),
    .i_in_valid (i_in_valid),
    .o_in_ready (o_in_ready),
    .i_data_in  (i_data_in),
    .i_shamt    (i_shamt),
    .i_mode     (i_mode),
    .o_out_valid(o_out_valid),
    .i_out_ready(i_out_ready),
    .o_data_out (o_data_out)
  );

  always #5 i_clock = ~i_clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  // Issue one request, scramble inputs after accept, measure latency, optionally
  // stall the result with a competing request, then complete the handshake.
  task automatic run_op(input string tag, input logic [1:0] mode, input logic [31:0] data,
                        input logic [4:0] shamt, input logic [31:0] exp, input int exp_lat,
                        input int hold);
    int lat;
    i_in_valid = 1'b1;
    i_data_in  = data;
    i_shamt    = shamt;
    i_mode     = mode;
    @(posedge i_clock); #1;
    i_in_valid = 1'b0;
    i_data_in  = 32'h0;
    i_shamt    = 5'h1f;
    i_mode     = ~mode;
    lat = -1;
    for (int e = 0; e <= 40; e++) begin
      if (o_out_valid) begin
        lat = e;
        break;
      end
      @(posedge i_clock); #1;
    end
    check({tag, " latency"}, 32'(lat), 32'(exp_lat));
    check({tag, " data"}, o_data_out, exp);
    check({tag, " in_ready in DONE"}, {31'b0, o_in_ready}, 32'd0);
    for (int h = 0; h < hold; h++) begin
      i_in_valid = 1'b1;
      i_data_in  = 32'hA5A5_5A5A;
      i_shamt    = 5'd0;
      @(posedge i_clock); #1;
      check({tag, " hold valid"}, {31'b0, o_out_valid}, 32'd1);
      check({tag, " hold data"}, o_data_out, exp);
      check({tag, " hold in_ready"}, {31'b0, o_in_ready}, 32'd0);
    end
    i_in_valid  = 1'b0;
    i_out_ready = 1'b1;
    @(posedge i_clock); #1;
    i_out_ready = 1'b0;
    check({tag, " idle after xfer"}, {30'b0, o_in_ready, o_out_valid}, 32'd2);
    if (hold > 0) check({tag, " no capture"}, o_data_out, exp);
  endtask

  initial begin
    int stale;
    i_reset     = 1'b1;
    i_in_valid  = 1'b0;
    i_data_in   = 32'h0;
    i_shamt     = 5'd0;
    i_mode      = SLL;
    i_out_ready = 1'b0;
    repeat (2) @(posedge i_clock);
    #1 i_reset = 1'b0;
    check("reset in_ready", {31'b0, o_in_ready}, 32'd1);
    check("reset out_valid", {31'b0, o_out_valid}, 32'd0);
    check("reset data_out", o_data_out, 32'h0);

    run_op("sra31", SRA, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF, 8, 0);
    run_op("srl31", SRL, 32'h8000_0000, 5'd31, 32'h0000_0001, 8, 0);
    run_op("sll4", SLL, 32'h0000_0001, 5'd4, 32'h0000_0010, 1, 0);
    run_op("ror8", ROR, 32'h1234_5678, 5'd8, 32'h7812_3456, 2, 0);
    run_op("srl0", SRL, 32'hDEAD_BEEF, 5'd0, 32'hDEAD_BEEF, 0, 0);
    run_op("sra5", SRA, 32'h8000_0000, 5'd5, 32'hFC00_0000, 2, 0);
    run_op("sra9pos", SRA, 32'h7FFF_FFFF, 5'd9, 32'h003F_FFFF, 3, 0);
    run_op("ror3", ROR, 32'h0000_000F, 5'd3, 32'hE000_0001, 1, 0);
    run_op("ror31", ROR, 32'h8000_0001, 5'd31, 32'h0000_0003, 8, 0);
    run_op("sll31", SLL, 32'hFFFF_FFFF, 5'd31, 32'h8000_0000, 8, 0);
    run_op("stall", ROR, 32'h1234_5678, 5'd8, 32'h7812_3456, 2, 5);

    // Reset in the middle of a multi-step SRA.
    i_in_valid = 1'b1;
    i_data_in  = 32'hF000_0000;
    i_shamt    = 5'd20;
    i_mode     = SRA;
    @(posedge i_clock); #1;
    i_in_valid = 1'b0;
    repeat (2) @(posedge i_clock);
    #1 i_reset = 1'b1;
    @(posedge i_clock); #1;
    i_reset = 1'b0;
    check("midshift rst in_ready", {31'b0, o_in_ready}, 32'd1);
    check("midshift rst out_valid", {31'b0, o_out_valid}, 32'd0);
    check("midshift rst data", o_data_out, 32'h0);
    stale = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge i_clock); #1;
      if (o_out_valid) stale++;
    end
    check("no stale result", 32'(stale), 32'd0);

    // Reset wins over out_ready while the result waits in DONE.
    i_in_valid = 1'b1;
    i_data_in  = 32'h0000_00FF;
    i_shamt    = 5'd4;
    i_mode     = SLL;
    @(posedge i_clock); #1;
    i_in_valid = 1'b0;
    @(posedge i_clock); #1;
    check("pre-rst done valid", {31'b0, o_out_valid}, 32'd1);
    check("pre-rst done data", o_data_out, 32'h0000_0FF0);
    i_reset     = 1'b1;
    i_out_ready = 1'b1;
    @(posedge i_clock); #1;
    i_reset     = 1'b0;
    i_out_ready = 1'b0;
    check("done rst state", {30'b0, o_in_ready, o_out_valid}, 32'd2);
    check("done rst data", o_data_out, 32'h0);

    run_op("post-rst sll1", SLL, 32'h0000_0003, 5'd1, 32'h0000_0006, 1, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/shift_iter.md
SHIFT_ITER -- requirements
Module: shift_iter

Interface
REQ-001 Parameter WIDTH, default 32, datapath width in bits; power of two, >= 8.
REQ-002 Parameter SHAMT_W, default 5, shift-amount width; SHALL equal log2(WIDTH).
REQ-003 Parameter STEP, default 4, maximum bits shifted per cycle; power of two, 1 <= STEP <= WIDTH/2.
REQ-004 clock  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 in_valid  input  1  request present.
REQ-007 in_ready  output  1  block can accept a request.
REQ-008 data_in  input  WIDTH  operand.
REQ-009 shamt  input  SHAMT_W  shift amount, unsigned, 0..WIDTH-1.
REQ-010 mode  input  2  00 SLL, 01 SRL, 10 SRA, 11 ROR (rotate right).
REQ-011 out_valid  output  1  result available.
REQ-012 out_ready  input  1  consumer takes the result.
REQ-013 data_out  output  WIDTH  result, registered.

Function
REQ-014 FSM SHALL have three states: IDLE, SHIFT, DONE.
REQ-015 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE; both registered-state decodes, no combinational path from inputs.
REQ-016 Accept: in IDLE with in_valid=1 at an edge, the block SHALL capture data_in into the working register, shamt into the remaining count, and mode.
REQ-017 On accept with shamt=0, next state SHALL be DONE with data_out = data_in unchanged; otherwise next state SHALL be SHIFT.
REQ-018 In SHIFT, each edge SHALL shift the working register by k = min(remaining, STEP) bits per the captured mode and decrement remaining by k.
REQ-019 When remaining becomes 0 at an edge, next state SHALL be DONE.
REQ-020 Latency: out_valid SHALL rise at the edge numbered ceil(shamt/STEP) counted from the accept edge as 0.
REQ-021 SLL fills vacated LSBs with 0; SRL fills vacated MSBs with 0.
REQ-022 SRA SHALL fill vacated MSBs with bit WIDTH-1 of the captured operand on every step, including multi-step shifts.
REQ-023 ROR SHALL move bits shifted out of bit 0 into bit WIDTH-1; total result equals rotate right by shamt.
REQ-024 Final result SHALL equal the single-step reference operation for every (data_in, shamt, mode) combination; no intermediate wrap or truncation.
REQ-025 data_out SHALL always present the working register; in DONE it SHALL hold stable until the handshake completes.
REQ-026 In DONE, out_ready=1 at an edge completes the transfer; next state SHALL be IDLE.
REQ-027 In DONE with out_ready=0, state, data_out and out_valid SHALL hold indefinitely.
REQ-028 in_valid while not in IDLE SHALL be ignored; no request is queued or lost state corrupted.
REQ-029 Back-to-back: a new request SHALL be acceptable no earlier than the cycle after DONE exits; min throughput one result per ceil(shamt/STEP)+2 cycles.
REQ-030 mode and shamt changes on inputs after accept SHALL have no effect on the in-flight operation.

Reset
REQ-031 reset=1 at an edge SHALL force IDLE, remaining=0, working register=0, regardless of current state.
REQ-032 After reset: in_ready=1, out_valid=0, data_out=0.
REQ-033 Reset mid-SHIFT or in DONE SHALL discard the in-flight operation; no result is ever presented for it.
REQ-034 reset has priority over accept and over out_ready completion in the same cycle.

Verification (WIDTH=32, STEP=4)
REQ-035 SRA, data_in=0x80000000, shamt=31 -> data_out=0xFFFFFFFF, out_valid rises 8 edges after accept.
REQ-036 SRL, data_in=0x80000000, shamt=31 -> data_out=0x00000001, 8 edges; SLL, 0x00000001, shamt=4 -> 0x00000010, 1 edge.
REQ-037 ROR, data_in=0x12345678, shamt=8 -> data_out=0x78123456, out_valid 2 edges after accept.
REQ-038 SRL, data_in=0xDEADBEEF, shamt=0 -> out_valid high the cycle after accept, data_out=0xDEADBEEF, in_ready=0 while DONE.
REQ-039 Result held with out_ready=0 for 5 cycles and in_valid=1 with new operand -> out_valid, data_out stable, in_ready=0, new operand not captured; out_ready=1 -> IDLE next cycle.
REQ-040 reset asserted during SHIFT of SRA 0xF0000000 by 20 -> next cycle IDLE, in_ready=1, out_valid=0, data_out=0; no stale result appears afterwards.
